instruction_fetch: RTL

- Front end of the 5-stage pipeline; produces `pc4`/`inst` for the decode stage.
- Consumes decode's `stall_en`, `pcsource`, `bpc`, `jpc` and a register jump target.
- Fetches over a single-outstanding req/ack instruction-memory port into a small prefetch FIFO.
- Drives the IF/ID pipeline register, including bubbles and squash on redirect.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/if_fifo.sv | 64 ++++++
 rtl/instruction_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the pipeline front end.
// IF_PERF_CNT_EN enables the fetch performance counters.
package cpu_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_REG = 2'b10;
    localparam logic [1:0] PCSRC_JMP = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP
    } if_state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of {pc4, inst} entries between imem and IF/ID.
// Flush wins over push and pop; DEPTH must be a power of two.
module if_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // The fetch FSM never pushes into a full FIFO unless a pop frees a slot.
    ovf_chk: assert property (
        @(posedge clk) disable iff (!clrn)
        !(push && full && !pop && !flush)
    );

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: imem req/ack port, prefetch FIFO, IF/ID register.
// Define IF_PERF_CNT_EN to add fetch_cnt/bubble_cnt outputs.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall_en,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RESET_ADDR = word_align(RESET_PC);

    if_state_t   state;
    if_state_t   state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nxt;
    logic [31:0] drop_addr;
    logic [31:0] drop_addr_nxt;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [CW-1:0] count;
    logic        fill_last;
    logic        room;
    logic [63:0] head;
    logic [63:0] push_data;
    if_id_t      head_s;

    assign redirect = (pcsource != PCSRC_SEQ) && !stall_en;

    always_comb begin
        target_raw = jpc;
        unique case (1'b1)
            pcsource == PCSRC_BR:  target_raw = bpc;
            pcsource == PCSRC_REG: target_raw = ra;
            default:               target_raw = jpc;
        endcase
    end

    assign target = word_align(target_raw);

    assign pop       = !stall_en && !redirect && !empty;
    assign fill_last = (count == CW'(FIFO_DEPTH - 1)) && !pop;
    // Room is judged on next-cycle occupancy so a drain restarts fetch at once.
    assign room      = redirect || pop || !full;
    assign push_data = {fetch_pc + 32'd4, imem_rdata};
    assign head_s    = if_id_t'(head);

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        drop_addr_nxt = drop_addr;
        push          = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = fetch_pc;
        unique case (state)
            IDLE: begin
                if (redirect)
                    fetch_pc_nxt = target;
                if (room)
                    state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack && redirect) begin
                    fetch_pc_nxt = target;
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    if (fill_last)
                        state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt     = DROP;
                    drop_addr_nxt = fetch_pc;
                    fetch_pc_nxt  = target;
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr;
                if (redirect)
                    fetch_pc_nxt = target;
                if (imem_ack)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            fetch_pc  <= RESET_ADDR;
            drop_addr <= RESET_ADDR;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            drop_addr <= drop_addr_nxt;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc4      <= '0;
            inst     <= NOP_INST;
            if_valid <= 1'b0;
        end else if (!stall_en) begin
            if (pop) begin
                pc4      <= head_s.pc4;
                inst     <= head_s.inst;
                if_valid <= 1'b1;
            end else begin
                pc4      <= '0;
                inst     <= NOP_INST;
                if_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (push)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (!stall_en && !pop)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
